atm_pin_entry: RTL
==================

# atm_pin_entry

Keypad front end for the ATM controller. It latches the account number when a card is inserted, collects a 4-digit BCD PIN from single-cycle key strobes, and presents `acc_num`/`pin` to the authenticator. It counts failed attempts and locks the card out, aborts on inactivity timeout, and holds a session-active flag after authentication succeeds. It sits directly upstream of the ATM menu FSM, which starts a session only while `session_active` is high.

## Interface
- `TIMEOUT_CYCLES`, default 1000: number of inactive cycles in ENTRY before the block aborts; must be at least 2.
- `MAX_ATTEMPTS`, default 3: failed PIN submissions allowed before lockout; range 1–3.
- `clk`  in  1: the one clock; all state updates on its rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `card_inserted`  in  1: level; high while a card is present.
- `card_acc_num`  in  4: account number read from the card; valid while `card_inserted` is high.
- `key_valid`  in  1: one-cycle strobe; `key_code` is valid in that cycle.
- `key_code`  in  4: 0x0–0x9 are digits, 0xA is ENTER, 0xB is CLEAR, 0xC is CANCEL; 0xD–0xF are ignored.
- `auth_done`  in  1: one-cycle strobe from the authenticator carrying the result.
- `auth_ok`  in  1: 1 means the PIN matched; sampled only when `auth_done` is high.
- `acc_num`  out  4: latched account number.
- `pin`  out  16: four BCD digits; the first digit entered ends up in `[15:12]`.
- `pin_valid`  out  1: level; high throughout SUBMIT.
- `digit_count`  out  3: number of digits entered, 0–4.
- `attempts_left`  out  2: remaining PIN attempts.
- `locked`  out  1: high in the LOCKED state.
- `session_active`  out  1: high in the GRANTED state.
- `timeout`  out  1: one-cycle pulse when the inactivity timer aborts an entry.

## Operation
- States: IDLE, ENTRY, SUBMIT, GRANTED, LOCKED.
- Reset values:
  - state IDLE
  - `acc_num`, `pin`, `digit_count` = 0
  - `attempts_left` = `MAX_ATTEMPTS`
  - all flags 0
  - inactivity counter 0
- Global priority: `card_inserted` = 0 in any state moves to IDLE and clears `acc_num`, `pin`, `digit_count` and the inactivity counter. This overrides every other event in the same cycle.
- IDLE, when `card_inserted` = 1:
  - latch `card_acc_num` into `acc_num`
  - set `attempts_left` to `MAX_ATTEMPTS`
  - go to ENTRY
- IDLE with the card still present after a prior exit (CANCEL or timeout): no new entry starts until `card_inserted` deasserts and reasserts. An edge detector on `card_inserted` enforces this.
- ENTRY key handling, applied only when `key_valid` = 1:
  - Digit with `digit_count` < 4: `pin` ← {`pin[11:0]`, `key_code`}; `digit_count` increments.
  - Digit with `digit_count` = 4: ignored.
  - CLEAR: `pin` = 0, `digit_count` = 0.
  - ENTER with `digit_count` = 4: go to SUBMIT.
  - ENTER with `digit_count` < 4: ignored.
  - CANCEL: go to IDLE; `acc_num` and `pin` are cleared.
  - 0xD–0xF: ignored; they still count as activity.
- ENTRY inactivity timer:
  - Any `key_valid` resets the counter to 0. Otherwise it increments each cycle.
  - When the counter reaches `TIMEOUT_CYCLES` - 1 with no key in that cycle: pulse `timeout`, clear `pin`, go to IDLE.
  - A key arriving in the same cycle as the terminal count wins; no timeout occurs.
- SUBMIT:
  - `pin` and `acc_num` are frozen; keys are ignored and the timer is held at 0.
  - `auth_done` with `auth_ok` = 1: go to GRANTED.
  - `auth_done` with `auth_ok` = 0: decrement `attempts_left`, clear `pin` and `digit_count`. If the new value is 0, go to LOCKED; otherwise go to ENTRY.
- GRANTED: `session_active` = 1; keys are ignored; the only exit is card removal.
- LOCKED: `locked` = 1; keys are ignored; the only exit is card removal.

## Timing
- Key latency: a key sampled at edge N updates `pin`, `digit_count` and state at edge N. The result is visible in cycle N+1.
- `pin_valid` rises in the cycle after ENTER is sampled, and falls in the cycle after `auth_done` is sampled.
- The earliest legal `auth_done` is the first cycle `pin_valid` is high. Zero-wait authenticators are supported.
- `auth_done` outside SUBMIT is ignored.
- Back-to-back `key_valid` on consecutive cycles: each strobe is processed independently.
- Reset asserted mid-operation, including during SUBMIT or LOCKED, returns every output to its reset value immediately. The lockout does not survive reset.
- Inactivity counter width is $clog2(`TIMEOUT_CYCLES`); it must not wrap.

## Test plan
- Card in with `card_acc_num` = 4'd7, keys 1,2,3,4, ENTER, then `auth_done` with `auth_ok` = 1 → `acc_num` = 7, `pin` = 16'h1234, `pin_valid` high for exactly the SUBMIT cycles, then `session_active` = 1.
- Keys 5,6, CLEAR, 9,8,7,6,5, ENTER → `pin` = 16'h9876; the fifth digit is ignored; SUBMIT is entered; an ENTER sent after only 3 digits is ignored.
- Three submissions each answered with `auth_ok` = 0 (`MAX_ATTEMPTS` = 3) → `attempts_left` goes 2, 1, 0, then `locked` = 1. Keys are then ignored. Card removal → IDLE with `locked` = 0.
- `TIMEOUT_CYCLES` = 8: card in, one digit, then no keys → `timeout` pulses once exactly 8 cycles after the last key, state IDLE, `pin` = 0. Repeat with a key in the terminal-count cycle → no timeout.
- Card removed during SUBMIT in the same cycle as `auth_done` with `auth_ok` = 1 → IDLE, `session_active` stays 0. Then `rst` pulsed low mid-ENTRY → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/atm_pin_entry_if.sv
// Card/keypad/authenticator signal bundle for the ATM PIN entry front end.
// No latency of its own: this is wiring only.
// No backpressure: every input is a level or a one-cycle strobe.
// Ports:
//   master: drives card, key and auth inputs and observes results.
//   slave:  the PIN entry block.
interface atm_pin_entry_if;
  logic        card_inserted;
  logic [3:0]  card_acc_num;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        auth_done;
  logic        auth_ok;
  logic [3:0]  acc_num;
  logic [15:0] pin;
  logic        pin_valid;
  logic [2:0]  digit_count;
  logic [1:0]  attempts_left;
  logic        locked;
  logic        session_active;
  logic        timeout;

  modport master (
    output card_inserted, card_acc_num, key_valid, key_code, auth_done, auth_ok,
    input  acc_num, pin, pin_valid, digit_count, attempts_left, locked,
           session_active, timeout
  );

  modport slave (
    input  card_inserted, card_acc_num, key_valid, key_code, auth_done, auth_ok,
    output acc_num, pin, pin_valid, digit_count, attempts_left, locked,
           session_active, timeout
  );
endinterface

// File: rtl/atm_pin_entry.sv
// ATM keypad front end: latches account, collects a 4-digit BCD PIN, tracks attempts, lockout and session.
// Latency: a key or auth strobe sampled at an edge is reflected in the outputs of the next cycle; timeout is combinational.
// Backpressure: none; every key and auth strobe is consumed (or ignored) in the cycle it is presented.
// Ports:
//   clk, rst (async, active low)
//   bus (slave): card_inserted/card_acc_num, key_valid/key_code, auth_done/auth_ok in;
//                acc_num, pin, pin_valid, digit_count, attempts_left, locked, session_active, timeout out.
module atm_pin_entry #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int MAX_ATTEMPTS   = 3
) (
  input  logic           clk,
  input  logic           rst,
  atm_pin_entry_if.slave bus
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    ATT_INIT = 2'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_SUBMIT,
    S_GRANTED,
    S_LOCKED
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    acc_q, acc_nxt;
  logic [15:0]   pin_q, pin_nxt;
  logic [2:0]    cnt_q, cnt_nxt;
  logic [1:0]    att_q, att_nxt;
  logic [TW-1:0] tmr_q, tmr_nxt;
  logic          card_prev;
  logic          timeout_c;

  logic key_digit, key_enter, key_clear, key_cancel;

  assign key_digit  = (bus.key_code <= 4'd9);
  assign key_enter  = (bus.key_code == 4'hA);
  assign key_clear  = (bus.key_code == 4'hB);
  assign key_cancel = (bus.key_code == 4'hC);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc_q;
    pin_nxt   = pin_q;
    cnt_nxt   = cnt_q;
    att_nxt   = att_q;
    tmr_nxt   = tmr_q;
    timeout_c = 1'b0;

    if (!bus.card_inserted) begin
      // Card removal beats every other event in the same cycle.
      state_nxt = S_IDLE;
      acc_nxt   = '0;
      pin_nxt   = '0;
      cnt_nxt   = '0;
      tmr_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Only a fresh insertion starts an entry; a card left in after
          // CANCEL or timeout must be pulled and reinserted.
          if (!card_prev) begin
            acc_nxt   = bus.card_acc_num;
            att_nxt   = ATT_INIT;
            tmr_nxt   = '0;
            state_nxt = S_ENTRY;
          end
        end

        S_ENTRY: begin
          if (bus.key_valid) begin
            // Any key, including the unused codes, counts as activity and
            // wins over a terminal count in the same cycle.
            tmr_nxt = '0;
            if (key_digit) begin
              if (cnt_q != 3'd4) begin
                pin_nxt = {pin_q[11:0], bus.key_code};
                cnt_nxt = cnt_q + 3'd1;
              end
            end else if (key_enter) begin
              if (cnt_q == 3'd4) state_nxt = S_SUBMIT;
            end else if (key_clear) begin
              pin_nxt = '0;
              cnt_nxt = '0;
            end else if (key_cancel) begin
              acc_nxt   = '0;
              pin_nxt   = '0;
              state_nxt = S_IDLE;
            end
          end else if (tmr_q == TMR_LAST) begin
            timeout_c = 1'b1;
            pin_nxt   = '0;
            tmr_nxt   = '0;
            state_nxt = S_IDLE;
          end else begin
            tmr_nxt = tmr_q + TW'(1);
          end
        end

        S_SUBMIT: begin
          tmr_nxt = '0;
          if (bus.auth_done) begin
            if (bus.auth_ok) begin
              state_nxt = S_GRANTED;
            end else begin
              att_nxt   = att_q - 2'd1;
              pin_nxt   = '0;
              cnt_nxt   = '0;
              state_nxt = (att_q == 2'd1) ? S_LOCKED : S_ENTRY;
            end
          end
        end

        default: begin
          // GRANTED and LOCKED hold until the card is removed.
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q     <= '0;
      pin_q     <= '0;
      cnt_q     <= '0;
      att_q     <= ATT_INIT;
      tmr_q     <= '0;
      card_prev <= 1'b0;
    end else begin
      acc_q     <= acc_nxt;
      pin_q     <= pin_nxt;
      cnt_q     <= cnt_nxt;
      att_q     <= att_nxt;
      tmr_q     <= tmr_nxt;
      card_prev <= bus.card_inserted;
    end
  end

  assign bus.acc_num        = acc_q;
  assign bus.pin            = pin_q;
  assign bus.digit_count    = cnt_q;
  assign bus.attempts_left  = att_q;
  assign bus.pin_valid      = (state == S_SUBMIT);
  assign bus.locked         = (state == S_LOCKED);
  assign bus.session_active = (state == S_GRANTED);
  assign bus.timeout        = timeout_c;

endmodule
